// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a word-only data memory, RMW for sub-word stores.
// Latency: load, word store and error respond 2 cycles after accept (accept edge counted); sub-word store 3.
// Backpressure: req_ready is high only in IDLE; one request in flight, next accept may share the response cycle.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ST_WR  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Captured request
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;

    // Old memory word held between the read and write halves of a sub-word store
    logic [DATA_WIDTH-1:0] r_merge;

    // Response registers
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic                  w_accept;
    logic                  w_req_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge_data;

    assign w_accept = req_valid && req_ready;

    // Alignment / size legality of the incoming request, judged before capture
    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            SZ_BYTE: w_req_err = 1'b0;
            SZ_HALF: w_req_err = req_addr[0];
            SZ_WORD: w_req_err = |req_addr[1:0];
            default: w_req_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; every non-idle state lasts exactly one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = S_ERR;
                    end else if (!req_we) begin
                        w_next_state = S_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        w_next_state = S_ST_WR;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   w_next_state = S_IDLE;
            S_ST_WR:  w_next_state = S_IDLE;
            S_RMW_RD: w_next_state = S_RMW_WR;
            S_RMW_WR: w_next_state = S_IDLE;
            S_ERR:    w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; dm_we stays combinational so a reset in RMW_WR still lets that write land
    always_comb begin
        req_ready = (r_state == S_IDLE);
        dm_we     = r_we && ((r_state == S_ST_WR) || (r_state == S_RMW_WR));
        dm_wdata  = (r_state == S_RMW_WR) ? w_merge_data : r_wdata;
    end

    // Word index: byte address with the lane bits dropped
    assign dm_addr = {2'b00, r_addr[ADDR_WIDTH-1:2]};

    // Lane selection and sign/zero extension of load data (little-endian lanes)
    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = dm_rdata[7:0];
            2'd1: w_byte = dm_rdata[15:8];
            2'd2: w_byte = dm_rdata[23:16];
            2'd3: w_byte = dm_rdata[31:24];
            default: w_byte = dm_rdata[7:0];
        endcase
        w_half = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        w_load_data = dm_rdata;
        case (r_size)
            SZ_BYTE: w_load_data = {{(DATA_WIDTH-8){r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{(DATA_WIDTH-16){r_signed & w_half[15]}}, w_half};
            default: w_load_data = dm_rdata;
        endcase
    end

    // Replace only the addressed lane(s) of the old word with the right-aligned store data
    always_comb begin
        w_merge_data = r_merge;
        if (r_size == SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0: w_merge_data[7:0]   = r_wdata[7:0];
                2'd1: w_merge_data[15:8]  = r_wdata[7:0];
                2'd2: w_merge_data[23:16] = r_wdata[7:0];
                2'd3: w_merge_data[31:24] = r_wdata[7:0];
                default: w_merge_data[7:0] = r_wdata[7:0];
            endcase
        end else if (r_size == SZ_HALF) begin
            if (r_addr[1]) begin
                w_merge_data[31:16] = r_wdata[15:0];
            end else begin
                w_merge_data[15:0] = r_wdata[15:0];
            end
        end
    end

    // Request capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            r_we     <= req_we;
        end
    end

    // Hold the old memory word during the read half of a sub-word store
    always_ff @(posedge clk) begin
        if (rst) begin
            r_merge <= '0;
        end else if (r_state == S_RMW_RD) begin
            r_merge <= dm_rdata;
        end
    end

    // Response generation on the edge leaving each terminal state; rdata holds until the next response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                S_ST_WR, S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                S_ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute-stage ALU result and the word-wide data memory.
- Converts byte, halfword and word loads/stores into word accesses on the memory port.
- Sub-word stores use a read-modify-write sequence, because the memory only writes full words.
- Loads are sign- or zero-extended. Misaligned requests are flagged and no write is performed.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the datapath and of the word address to memory.
- DATA_WIDTH, 32, data width. Fixed at 32; byte-lane logic is defined for 4 lanes only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse for load or store
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or reserved-size request; valid with resp_valid
- dm_addr  output  ADDR_WIDTH  word index to memory, {2'b00, addr_q[ADDR_WIDTH-1:2]}
- dm_wdata  output  DATA_WIDTH  word to write
- dm_we  output  1  memory write enable
- dm_rdata  input  DATA_WIDTH  memory read data, combinational from dm_addr

Behaviour:
- Request capture: a request is accepted on a rising edge where req_valid && req_ready. At acceptance, all req_* fields are registered (addr_q, size_q, signed_q, wdata_q, we_q).
- Byte lane: lane = addr_q[1:0], little-endian, so lane 0 is bits [7:0].
  - Halfword at addr_q[1]=0 occupies [15:0]; at addr_q[1]=1 it occupies [31:16].
- Error: raised on any of the following, checked at accept:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_size=11.
  - Effect: next state is ERR; no memory access, dm_we never asserted.
- States: IDLE, LOAD, ST_WR, RMW_RD, RMW_WR, ERR.
- IDLE: req_ready=1. On accept the next state is chosen as follows:
  - error -> ERR;
  - load -> LOAD;
  - word store -> ST_WR;
  - byte/half store -> RMW_RD.
- LOAD (1 cycle):
  - Drive dm_addr; extract the selected lane from dm_rdata and extend it per signed_q.
  - Register the result into resp_rdata and set resp_valid at the edge -> IDLE.
- ST_WR (1 cycle): dm_we=1, dm_wdata=wdata_q. The memory writes at the edge leaving the state; resp_valid is set at that edge -> IDLE.
- RMW_RD (1 cycle): capture dm_rdata into merge_q -> RMW_WR.
- RMW_WR (1 cycle): dm_we=1, dm_wdata = merge_q with only the target lane(s) replaced by wdata_q[7:0] or wdata_q[15:0]. resp_valid is set at the exiting edge -> IDLE.
- ERR (1 cycle): resp_valid=1, resp_err=1, resp_rdata=0 set at the exiting edge -> IDLE.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 2 cycles.
- Back-to-back operation: the resp_valid cycle coincides with IDLE, so a new request may be accepted in that same cycle.
- Response outputs: resp_valid and resp_err are single-cycle pulses, cleared the following edge. resp_rdata holds its value until the next response.
- dm_we: combinational, high only in ST_WR or RMW_WR. Never high in IDLE, LOAD, RMW_RD or ERR.
- dm_addr / dm_wdata: driven from registers in all states; their value in IDLE is don't-care.
- Reset: synchronous rst forces the following at the next edge, with priority over everything:
  - state=IDLE;
  - addr_q, wdata_q, merge_q, resp_rdata = 0;
  - resp_valid = 0, resp_err = 0;
  - dm_we therefore 0.
- Reset mid-operation: reset asserted during RMW_RD or RMW_WR aborts the operation. If it is asserted in the RMW_WR cycle, dm_we stays high in that cycle (combinational from state), so the write still lands at that edge as the state returns to IDLE; no response is issued.
- Address range: dm_addr passes the full word index. Range folding is the memory's responsibility.

Test Plan:
- Word store then load: store word 0x0000_0010 = 0xDEADBEEF, then load word signed.
  - Store: dm_we high exactly 1 cycle, resp_valid 2 cycles after accept.
  - Load: resp_rdata=0xDEADBEEF, resp_err=0.
- Byte RMW: memory word at byte addr 0x10 = 0xDEADBEEF; store byte 0x55 at 0x12.
  - dm_wdata in RMW_WR = 0xDE55BEEF; resp_valid 3 cycles after accept.
  - Word 0x10 reads back 0xDE55BEEF.
- Extension: word 0x10 = 0x8080_7F80.
  - load byte signed @0x10 -> 0xFFFFFF80;
  - load byte unsigned @0x10 -> 0x00000080;
  - load half signed @0x12 -> 0xFFFF8080;
  - load half signed @0x10 -> 0x00007F80.
- Misalignment: load half @0x11 and store word @0x16.
  - resp_err=1, resp_rdata=0, dm_we never high.
  - The memory word is unchanged.
- Back-to-back: hold req_valid high for 4 consecutive word loads.
  - Each load is accepted in the cycle its predecessor's resp_valid is high.
  - Throughput is 1 response per 2 cycles.
- Reset mid-RMW: assert rst in the RMW_RD cycle of a byte store.
  - No dm_we pulse and no resp_valid.
  - Next cycle: req_ready=1, resp_rdata=0.
